// File: rtl/aes_mix_columns_pipe.sv
// AES MixColumns / InvMixColumns engine that transforms COLS_PER_CYCLE columns per clock.
// The optional pass-through mode for the final AES round is enabled by defining
// AES_MIXCOL_BYPASS_EN, which adds the s_bypass input.
// With OUT_REG=1, the result is copied into a dedicated output register one cycle after
// the engine finishes. While in DONE, s_ready follows m_ready only once m_valid is up, so
// a new state is never accepted before the previous result has actually been presented.
module aes_mix_columns_pipe #(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter int unsigned OUT_REG        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_inv,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic         s_bypass,
`endif
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data
);

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned NCOLS    = 4;
    localparam int unsigned CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCOLS - COLS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_work;
    logic                r_inv;
`ifdef AES_MIXCOL_BYPASS_EN
    logic                r_byp;
`endif
    logic [DATA_W-1:0]   w_work_nxt;
    logic                w_accept;
    logic                w_last;

    // GF(2^8) multiply by x, reduced by 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant as a sum of x-powers
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & b2) ^ ({8{k[2]}} & b4) ^ ({8{k[3]}} & b8);
    endfunction

    // One column through the circulant matrix (02 03 01 01) or (0E 0B 0D 09)
    function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col, input logic inv);
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic [3:0] k [4];
        logic [7:0] acc;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        if (inv) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ gf_mul(a[2'(i + j)], k[2'(j)]);
            end
            b[2'(i)] = acc;
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    assign w_accept = s_valid && s_ready;
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_LAST);

    // Next-state and input-ready decode
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_ready = r_run;
                if (s_valid && r_run) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                s_ready = m_ready && m_valid;
                if (m_valid && m_ready) begin
                    w_state_nxt = s_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; r_run keeps s_ready low until the first edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // Transform the column group selected by the counter, leave the rest untouched
    always_comb begin
        w_work_nxt = r_work;
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            w_work_nxt[{~(r_cnt + CNT_W'(j)), 5'b0} +: COL_W] =
                mix_col(r_work[{~(r_cnt + CNT_W'(j)), 5'b0} +: COL_W], r_inv);
        end
`ifdef AES_MIXCOL_BYPASS_EN
        if (r_byp) begin
            w_work_nxt = r_work;
        end
`endif
    end

    // Working register, column counter and per-transfer controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_inv  <= 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
            r_byp  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_work <= s_data;
            r_inv  <= s_inv;
`ifdef AES_MIXCOL_BYPASS_EN
            r_byp  <= s_bypass;
`endif
        end else if (r_state == ST_BUSY) begin
            r_work <= w_work_nxt;
            r_cnt  <= w_last ? '0 : r_cnt + CNT_INC;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              r_m_valid;
        logic [DATA_W-1:0] r_m_data;

        // Capture the finished state one cycle after DONE entry and hold it until taken
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_m_valid <= 1'b0;
                r_m_data  <= '0;
            end else if ((r_state == ST_DONE) && !r_m_valid) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_work;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end

        assign m_valid = r_m_valid;
        assign m_data  = r_m_data;
    end else begin : g_out_direct
        assign m_valid = (r_state == ST_DONE);
        assign m_data  = r_work;
    end

endmodule

// File: tb/tb_aes_mix_columns_pipe.sv
// Self-checking bench for aes_mix_columns_pipe: directed vectors, back-pressure,
// streaming, round trip, mid-operation reset and a COLS_PER_CYCLE x OUT_REG sweep.
module tb_aes_mix_columns_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_inv;
`ifdef AES_MIXCOL_BYPASS_EN
    logic         s_bypass;
`endif
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit sweep_go = 1'b0;

    always #5 clk = ~clk;

    aes_mix_columns_pipe #(.COLS_PER_CYCLE(1), .OUT_REG(1)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_inv   (s_inv),
`ifdef AES_MIXCOL_BYPASS_EN
        .s_bypass(s_bypass),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Field multiplication modulo x^8+x^4+x^3+x+1 by shift-and-add
    function automatic int gmul(input int a, input int b);
        int p;
        int x;
        int y;
        p = 0;
        x = a;
        y = b;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return p;
    endfunction

    // Whole-state matrix product: out[r] of column c = sum_j M[r][j] * in[j]
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        int coef [4];
        int a [16];
        int acc;
        logic [127:0] r;
        if (inv) coef = '{14, 11, 13, 9};
        else     coef = '{2, 3, 1, 1};
        for (int i = 0; i < 16; i++) a[i] = int'(s >> (8 * (15 - i))) & 255;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[4 * c + j], coef[(j - row + 4) % 4]);
                r = r | (128'(acc) << (8 * (15 - (4 * c + row))));
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete transfer with m_ready high; returns result and accept-to-valid latency
    task automatic xfer(input logic [127:0] d, input bit inv, input bit byp,
                        output logic [127:0] res, output int lat);
        int n;
        @(negedge clk);
        s_data  = d;
        s_inv   = inv;
`ifdef AES_MIXCOL_BYPASS_EN
        s_bypass = byp;
`else
        if (byp) s_inv = inv;
`endif
        s_valid = 1'b1;
        m_ready = 1'b1;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("accept_timeout", 128'(s_ready), 128'(1));
            s_valid = 1'b0;
            res = '0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = rand128();
        s_inv   = ~inv;
`ifdef AES_MIXCOL_BYPASS_EN
        s_bypass = ~byp;
`endif
        lat = 0;
        while (!m_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!m_valid) chk("resp_timeout", 128'(m_valid), 128'(1));
        res = m_data;
        @(posedge clk);
        #1;
    endtask

    // Sweep: every legal COLS_PER_CYCLE with both OUT_REG settings
    for (genvar g = 0; g < 6; g++) begin : g_sweep
        localparam int unsigned C   = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
        localparam int unsigned ORG = g / 3;
        localparam int unsigned EXP_LAT = 4 / C + ORG;
        logic         sv;
        logic         sr;
        logic [127:0] sd;
        logic         si;
        logic         mv;
        logic         mr;
        logic [127:0] md;
        bit           done = 1'b0;

        aes_mix_columns_pipe #(.COLS_PER_CYCLE(C), .OUT_REG(ORG)) u_sw (
            .clk     (clk),
            .rst     (rst),
            .s_valid (sv),
            .s_ready (sr),
            .s_data  (sd),
            .s_inv   (si),
`ifdef AES_MIXCOL_BYPASS_EN
            .s_bypass(1'b0),
`endif
            .m_valid (mv),
            .m_ready (mr),
            .m_data  (md)
        );

        initial begin : p_sweep
            logic [127:0] d;
            bit inv;
            int n;
            int lat;
            sv = 1'b0;
            sd = '0;
            si = 1'b0;
            mr = 1'b1;
            wait (sweep_go);
            for (int t = 0; t < 6; t++) begin
                d   = rand128();
                inv = 1'($urandom_range(0, 1));
                @(negedge clk);
                sd = d;
                si = inv;
                sv = 1'b1;
                n = 0;
                while (!sr && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("sweep%0d_accept", g), 128'(sr), 128'(1));
                @(posedge clk);
                #1;
                sv = 1'b0;
                sd = ~d;
                si = ~inv;
                lat = 0;
                while (!mv && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                chk($sformatf("sweep%0d_lat", g), 128'(lat), 128'(EXP_LAT));
                chk($sformatf("sweep%0d_data", g), md, ref_mix(d, inv));
                @(posedge clk);
                #1;
            end
            done = 1'b1;
        end
    end

    initial begin : p_main
        logic [127:0] d, d2, y, z, res;
        bit inv, inv2;
        int lat, n, cyc, last_acc, launched, outs;
        logic [127:0] exp_q [$];

        s_valid = 1'b0;
        s_data  = '0;
        s_inv   = 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
        s_bypass = 1'b0;
`endif
        m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_data", m_data, 128'(0));
        rst = 1'b0;
        #1;
        chk("rst_ready_before_edge", 128'(s_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rst_ready_rise", 128'(s_ready), 128'(1));

        // Forward reference column
        xfer({4{32'hdb135345}}, 1'b0, 1'b0, res, lat);
        chk("fwd_vec_data", res, {4{32'h8e4da1bc}});
        chk("fwd_vec_lat", 128'(lat), 128'(5));

        // Inverse reference columns
        xfer({32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6}, 1'b1, 1'b0, res, lat);
        chk("inv_vec_data", res, {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5});
        chk("inv_vec_lat", 128'(lat), 128'(5));

        // Random states, random direction
        for (int t = 0; t < 10; t++) begin
            d   = rand128();
            inv = 1'($urandom_range(0, 1));
            xfer(d, inv, 1'b0, res, lat);
            chk("rand_data", res, ref_mix(d, inv));
            chk("rand_lat", 128'(lat), 128'(5));
        end

        // Back-pressure, then accept in the same cycle as the output handshake
        @(negedge clk);
        m_ready = 1'b0;
        d    = rand128();
        inv  = 1'($urandom_range(0, 1));
        d2   = rand128();
        inv2 = 1'($urandom_range(0, 1));
        s_data  = d;
        s_inv   = inv;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_data = d2;
        s_inv  = inv2;
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_lat", 128'(n), 128'(5));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 128'(m_valid), 128'(1));
            chk("bp_hold_data", m_data, ref_mix(d, inv));
            chk("bp_hold_ready", 128'(s_ready), 128'(0));
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(s_ready), 128'(1));
        @(posedge clk);
        #1;
        chk("bp_next_inflight", 128'(m_valid), 128'(0));
        s_valid = 1'b0;
        s_data  = rand128();
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_next_lat", 128'(n), 128'(5));
        chk("bp_next_data", m_data, ref_mix(d2, inv2));
        @(posedge clk);
        #1;

        // Streaming with s_valid and m_ready held high: no idle bubble between transfers
        m_ready  = 1'b1;
        launched = 0;
        outs     = 0;
        cyc      = 0;
        last_acc = -1;
        @(negedge clk);
        d   = rand128();
        inv = 1'($urandom_range(0, 1));
        s_data  = d;
        s_inv   = inv;
        s_valid = 1'b1;
        while (outs < 6 && cyc < 300) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() > 0) chk("stream_data", m_data, exp_q.pop_front());
                else chk("stream_spurious", 128'(m_valid), 128'(0));
                outs++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(ref_mix(d, inv));
                if (last_acc >= 0) chk("stream_gap", 128'(cyc - last_acc), 128'(6));
                last_acc = cyc;
                launched++;
                @(posedge clk);
                #1;
                if (launched < 6) begin
                    d   = rand128();
                    inv = 1'($urandom_range(0, 1));
                    s_data = d;
                    s_inv  = inv;
                end else begin
                    s_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        chk("stream_count", 128'(outs), 128'(6));
        @(posedge clk);
        #1;

        // Round trip
        d = rand128();
        xfer(d, 1'b0, 1'b0, y, lat);
        chk("rt_fwd", y, ref_mix(d, 1'b0));
        xfer(y, 1'b1, 1'b0, z, lat);
        chk("rt_back", z, d);

        // Reset while BUSY abandons the transfer
        @(negedge clk);
        s_data  = rand128();
        s_inv   = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstb_m_valid", 128'(m_valid), 128'(0));
        chk("rstb_m_data", m_data, 128'(0));
        chk("rstb_s_ready", 128'(s_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) n++;
        end
        chk("rstb_no_output", 128'(n), 128'(0));
        d   = rand128();
        inv = 1'($urandom_range(0, 1));
        xfer(d, inv, 1'b0, res, lat);
        chk("rstb_after_data", res, ref_mix(d, inv));
        chk("rstb_after_lat", 128'(lat), 128'(5));

`ifdef AES_MIXCOL_BYPASS_EN
        // Pass-through transfers keep the normal latency
        xfer(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1, res, lat);
        chk("byp_data", res, 128'h00112233445566778899aabbccddeeff);
        chk("byp_lat", 128'(lat), 128'(5));
        d = rand128();
        xfer(d, 1'b1, 1'b1, res, lat);
        chk("byp_inv_data", res, d);
        d = rand128();
        xfer(d, 1'b1, 1'b0, res, lat);
        chk("byp_off_data", res, ref_mix(d, 1'b1));
`endif

        // Parameter sweep
        sweep_go = 1'b1;
        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                 g_sweep[3].done && g_sweep[4].done && g_sweep[5].done) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("sweep_timeout", 128'(n), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
